// File: rtl/vga_pkg.sv
// Shared VGA display constants and framebuffer arbiter types.
// HDISP/VDISP defaults are common to the timing generator and the framebuffer arbiter.
package vga_pkg;

  localparam int VGA_HDISP = 800;
  localparam int VGA_VDISP = 480;
  localparam int FB_WORDS  = VGA_HDISP * VGA_VDISP;

  localparam int FB_BURST      = 16;
  localparam int FB_FIFO_DEPTH = 256;
  localparam int FB_AW         = 19;
  localparam int FB_DW         = 32;
  localparam int FB_MAX_VID    = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VID_BURST = 2'd1,
    HOST_WR   = 2'd2
  } fb_arb_state_t;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: display line fetch in fixed read bursts with priority,
// single-word host writes admitted after MAX_VID consecutive bursts while the host waits.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int HDISP      = VGA_HDISP,
  parameter int VDISP      = VGA_VDISP,
  parameter int BURST      = FB_BURST,
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH,
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int MAX_VID    = FB_MAX_VID
) (
  input  logic                          pixel_clk,
  input  logic                          pixel_rst_n,
  input  logic                          frame_start,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pix_wr,
  output logic [DW-1:0]                 pix_data,
  input  logic                          host_req,
  input  logic [AW-1:0]                 host_addr,
  input  logic [DW-1:0]                 host_wdata,
  output logic                          host_ack,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [DW-1:0]                 mem_rdata
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = LW + 1;
  localparam int BW = $clog2(BURST);
  localparam int CW = $clog2(MAX_VID + 1);

  localparam logic [AW-1:0] FB_LAST   = AW'(HDISP * VDISP - 1);
  localparam logic [SW-1:0] VID_LIMIT = SW'(FIFO_DEPTH - BURST);

  fb_arb_state_t   state_q,      state_d;
  logic [AW-1:0]   vid_addr_q,   vid_addr_d;
  logic [LW-1:0]   inflight_q,   inflight_d;
  logic [CW-1:0]   vid_cnt_q,    vid_cnt_d;
  logic [BW-1:0]   beat_q,       beat_d;
  logic            frame_done_q, frame_done_d;
  logic            fs_pend_q,    fs_pend_d;
  logic            rd_armed_q,   rd_armed_d;
  logic            mem_req_q,    mem_req_d;
  logic            mem_we_q,     mem_we_d;
  logic [AW-1:0]   mem_addr_q,   mem_addr_d;
  logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
  logic            host_ack_q,   host_ack_d;
  logic            pix_wr_q,     pix_wr_d;
  logic [DW-1:0]   pix_data_q,   pix_data_d;

  logic            rd_gnt;
  logic            wr_gnt;
  logic            rd_ret;
  logic            go_decide;
  logic            vid_ok;
  logic            host_pend;
  logic [LW-1:0]   dec_inflight;
  logic [SW-1:0]   level_sum;

  assign rd_gnt = (state_q == VID_BURST) && mem_req_q && mem_gnt;
  assign wr_gnt = (state_q == HOST_WR) && mem_req_q && mem_gnt;
  // Returns are only trusted once a read has been issued since reset.
  assign rd_ret = mem_rvalid && rd_armed_q;

  always_comb begin
    state_d      = state_q;
    vid_addr_d   = vid_addr_q;
    inflight_d   = inflight_q;
    vid_cnt_d    = vid_cnt_q;
    beat_d       = beat_q;
    frame_done_d = frame_done_q;
    fs_pend_d    = fs_pend_q;
    rd_armed_d   = rd_armed_q | rd_gnt;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    host_ack_d   = 1'b0;
    pix_wr_d     = rd_ret;
    pix_data_d   = rd_ret ? mem_rdata : pix_data_q;
    go_decide    = 1'b0;
    vid_ok       = 1'b0;
    host_pend    = 1'b0;
    dec_inflight = inflight_q;
    level_sum    = '0;

    if (rd_gnt && !rd_ret) begin
      inflight_d = inflight_q + LW'(1);
    end else if (!rd_gnt && rd_ret && inflight_q != '0) begin
      inflight_d = inflight_q - LW'(1);
    end

    case (state_q)
      IDLE: begin
        // A restart is applied first; the fetch decision follows a cycle later.
        if (frame_start) begin
          vid_addr_d   = '0;
          frame_done_d = 1'b0;
        end else begin
          go_decide = 1'b1;
        end
      end

      VID_BURST: begin
        if (frame_start) fs_pend_d = 1'b1;
        if (rd_gnt) begin
          beat_d = beat_q + BW'(1);
          if (vid_addr_q == FB_LAST) begin
            vid_addr_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            vid_addr_d = vid_addr_q + AW'(1);
          end
          mem_addr_d = vid_addr_d;
          if (beat_q == BW'(BURST - 1)) begin
            if (fs_pend_q || frame_start) begin
              vid_addr_d   = '0;
              frame_done_d = 1'b0;
              fs_pend_d    = 1'b0;
            end
            if (!host_req)                       vid_cnt_d = '0;
            else if (vid_cnt_q != CW'(MAX_VID)) vid_cnt_d = vid_cnt_q + CW'(1);
            mem_req_d = 1'b0;
            state_d   = IDLE;
            // Chain straight into the next decision so back-to-back bursts leave no gap.
            go_decide = 1'b1;
          end
        end
      end

      HOST_WR: begin
        if (frame_start) begin
          vid_addr_d   = '0;
          frame_done_d = 1'b0;
        end
        if (wr_gnt) begin
          host_ack_d = 1'b1;
          vid_cnt_d  = '0;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (go_decide) begin
      dec_inflight = (state_q == IDLE) ? inflight_q : inflight_d;
      level_sum    = SW'(fifo_level) + SW'(dec_inflight);
      vid_ok       = !frame_done_d && (level_sum <= VID_LIMIT);
      // The request still sits high in the cycle its ack is visible; do not serve it twice.
      host_pend    = host_req && !host_ack_q;
      if (vid_ok && !(host_pend && vid_cnt_d == CW'(MAX_VID))) begin
        state_d    = VID_BURST;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = vid_addr_d;
        beat_d     = '0;
      end else if (host_pend) begin
        state_d     = HOST_WR;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = host_addr;
        mem_wdata_d = host_wdata;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q      <= IDLE;
      vid_addr_q   <= '0;
      inflight_q   <= '0;
      vid_cnt_q    <= '0;
      beat_q       <= '0;
      frame_done_q <= 1'b1;
      fs_pend_q    <= 1'b0;
      rd_armed_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      host_ack_q   <= 1'b0;
      pix_wr_q     <= 1'b0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      vid_addr_q   <= vid_addr_d;
      inflight_q   <= inflight_d;
      vid_cnt_q    <= vid_cnt_d;
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
      fs_pend_q    <= fs_pend_d;
      rd_armed_q   <= rd_armed_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      host_ack_q   <= host_ack_d;
      pix_wr_q     <= pix_wr_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign host_ack  = host_ack_q;
  assign pix_wr    = pix_wr_q;
  assign pix_data  = pix_data_q;

  a_no_orphan_rvalid: assert property (@(posedge pixel_clk) disable iff (!pixel_rst_n)
    !(mem_rvalid && rd_armed_q && inflight_q == '0));

  a_inflight_bound: assert property (@(posedge pixel_clk) disable iff (!pixel_rst_n)
    inflight_q <= LW'(FIFO_DEPTH));

endmodule
